// File: rtl/uart_debug_ctrl_if.sv
// Host-side bundle between the UART debug controller, the UART RX/TX FIFO
// and the pipeline debug-word mux.
interface uart_debug_ctrl_if #(
    parameter int unsigned SEL_W = 6
);
    logic [7:0]       rx_data;
    logic             rx_data_rdy;
    logic             fifo_full;
    logic             halted;
    logic [31:0]      dbg_word;
    logic [7:0]       w_data;
    logic             write_enable;
    logic [SEL_W-1:0] word_sel;
    logic             pipe_en;
    logic             debug_mode;

    // Controller side
    modport slave (
        input  rx_data,
        input  rx_data_rdy,
        input  fifo_full,
        input  halted,
        input  dbg_word,
        output w_data,
        output write_enable,
        output word_sel,
        output pipe_en,
        output debug_mode
    );

    // Environment side: UART RX, TX FIFO, pipeline
    modport master (
        output rx_data,
        output rx_data_rdy,
        output fifo_full,
        output halted,
        output dbg_word,
        input  w_data,
        input  write_enable,
        input  word_sel,
        input  pipe_en,
        input  debug_mode
    );
endinterface

// File: rtl/uart_debug_ctrl.sv
// UART debug command controller: run / single-step / pause the MIPS pipeline
// and dump N_WORDS debug words to the TX FIFO, MSB byte first.
module uart_debug_ctrl #(
    parameter int unsigned N_WORDS = 40,
    parameter int unsigned SEL_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    uart_debug_ctrl_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 2;

    localparam logic [BYTE_W-1:0] CMD_RUN   = 8'h63;
    localparam logic [BYTE_W-1:0] CMD_STEP  = 8'h73;
    localparam logic [BYTE_W-1:0] CMD_DUMP  = 8'h64;
    localparam logic [BYTE_W-1:0] CMD_PAUSE = 8'h70;
    localparam logic [BYTE_W-1:0] NAK_CHAR  = 8'h3F;

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_LOAD,
        S_BYTE,
        S_NAK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [CNT_W-1:0]  w_byte_cnt_nxt;
    logic [SEL_W-1:0]  r_word_sel;
    logic [SEL_W-1:0]  w_word_sel_nxt;
    logic [BYTE_W-1:0] r_w_data;
    logic [BYTE_W-1:0] w_w_data_nxt;
    logic              r_pipe_en;
    logic              w_pipe_en_nxt;
    logic              r_debug_mode;
    logic              w_debug_mode_nxt;
    logic              w_push;

    // Push strobe follows the FIFO flag within the cycle; reset cuts it off at once
    assign w_push = rst && !bus.fifo_full && ((r_state == S_BYTE) || (r_state == S_NAK));

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        w_word_sel_nxt = r_word_sel;

        case (r_state)
            S_IDLE: begin
                if (bus.rx_data_rdy) begin
                    case (bus.rx_data)
                        CMD_RUN:  w_state_nxt = S_RUN;
                        CMD_STEP: w_state_nxt = S_STEP;
                        CMD_DUMP: begin
                            w_state_nxt    = S_LOAD;
                            w_word_sel_nxt = '0;
                        end
                        default:  w_state_nxt = S_NAK;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.halted || (bus.rx_data_rdy && (bus.rx_data == CMD_PAUSE))) begin
                    w_state_nxt    = S_LOAD;
                    w_word_sel_nxt = '0;
                end
            end
            S_STEP: begin
                w_state_nxt    = S_LOAD;
                w_word_sel_nxt = '0;
            end
            S_LOAD: begin
                w_shift_nxt    = bus.dbg_word;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = S_BYTE;
            end
            S_BYTE: begin
                if (w_push) begin
                    w_shift_nxt    = {r_shift[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
                    w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    if (r_byte_cnt == LAST_BYTE) begin
                        if (r_word_sel == LAST_IDX) begin
                            w_state_nxt    = S_IDLE;
                            w_word_sel_nxt = '0;
                        end else begin
                            w_state_nxt    = S_LOAD;
                            w_word_sel_nxt = r_word_sel + SEL_W'(1);
                        end
                    end
                end
            end
            S_NAK: begin
                if (w_push) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it
    always_comb begin
        w_w_data_nxt     = r_w_data;
        w_pipe_en_nxt    = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
        w_debug_mode_nxt = (w_state_nxt != S_RUN);
        if (w_state_nxt == S_BYTE) begin
            w_w_data_nxt = w_shift_nxt[WORD_W-1 -: BYTE_W];
        end else if (w_state_nxt == S_NAK) begin
            w_w_data_nxt = NAK_CHAR;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_word_sel   <= '0;
            r_w_data     <= '0;
            r_pipe_en    <= 1'b0;
            r_debug_mode <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_word_sel   <= w_word_sel_nxt;
            r_w_data     <= w_w_data_nxt;
            r_pipe_en    <= w_pipe_en_nxt;
            r_debug_mode <= w_debug_mode_nxt;
        end
    end

    assign bus.w_data       = r_w_data;
    assign bus.write_enable = w_push;
    assign bus.word_sel     = r_word_sel;
    assign bus.pipe_en      = r_pipe_en;
    assign bus.debug_mode   = r_debug_mode;

endmodule

// File: doc/uart_debug_ctrl.md
Name: uart_debug_ctrl

Overview:
Debug command controller that sits directly downstream of the UART receiver and upstream of its TX FIFO. It consumes received command bytes (rx_data/rx_data_rdy) and controls the MIPS pipeline clock enable: run, single-step and pause. It dumps N_WORDS 32-bit debug words (registers, PC, pipeline latches) back to the host as bytes on w_data/write_enable, honouring the FIFO full flag.

Parameters:
N_WORDS, 40, number of 32-bit debug words sent per dump (indices 0..N_WORDS-1)
SEL_W, 6, width of word_sel; must satisfy 2^SEL_W >= N_WORDS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
rx_data  in  8  received byte from UART RX
rx_data_rdy  in  1  one-cycle pulse, rx_data valid
fifo_full  in  1  TX FIFO full; no write allowed while high
halted  in  1  pipeline reached HALT instruction (level)
dbg_word  in  32  debug word selected by word_sel (combinational mux outside, valid same cycle)
w_data  out  8  byte to TX FIFO
write_enable  out  1  TX FIFO push strobe
word_sel  out  SEL_W  index of debug word being read
pipe_en  out  1  pipeline clock enable
debug_mode  out  1  1 = stepping/halted, 0 = free run

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, debug_mode=1, pipe_en=0, write_enable=0, w_data=0, word_sel=0, byte_cnt=0, shift reg=0. Reset mid-dump aborts immediately; no further bytes are pushed.
- States: IDLE, RUN, STEP, LOAD, BYTE, NAK.
- IDLE: on rx_data_rdy:
  - 0x63 'c' -> RUN.
  - 0x73 's' -> STEP.
  - 0x64 'd' -> LOAD with word_sel=0.
  - any other byte -> NAK.
  - No rx_data_rdy -> stay in IDLE.
- RUN: pipe_en=1 and debug_mode=0 every cycle.
  - halted=1 -> LOAD (word_sel=0), pipe_en=0 from the next cycle.
  - rx 0x70 'p' -> LOAD (word_sel=0); halted wins if both occur in the same cycle (same destination).
  - Other bytes in RUN are ignored.
- STEP: pipe_en=1 for exactly one cycle, debug_mode=1 -> LOAD (word_sel=0). If halted=1 on entry, the step pulse is still issued.
- LOAD: word_sel=idx; at the clk edge capture dbg_word into the 32-bit shift reg, byte_cnt=0 -> BYTE.
- BYTE:
  - write_enable = !fifo_full (combinational from state); w_data = shift[31:24] (MSB first).
  - On each edge with write_enable=1: shift left 8, byte_cnt++.
  - After the 4th byte: if idx==N_WORDS-1 -> IDLE, word_sel=0; else idx++ -> LOAD.
  - While fifo_full=1: hold, write_enable=0, w_data stable.
- NAK: write_enable = !fifo_full, w_data=0x3F '?'; after one accepted push -> IDLE.
- rx_data_rdy in LOAD/BYTE/NAK/STEP is dropped (no queueing).
- Latency: 'd' pulse at cycle T -> LOAD at T+1 -> first write_enable at T+2 if FIFO not full. Full dump, no backpressure, takes 5*N_WORDS cycles.
- debug_mode=0 only in RUN; 1 in all other states.
- Outputs w_data and word_sel hold their last value when unused; write_enable is never high outside BYTE/NAK.

Test Plan:
- Reset: rst=0 for 3 cycles -> debug_mode=1, pipe_en=0, write_enable=0, word_sel=0.
- Dump: dbg_word=0xA0000000+word_sel, rx 'd' -> 160 pushes (N_WORDS=40); first four are A0,00,00,00 starting at T+2; last four are A0,00,00,27; then IDLE.
- Backpressure: during a dump, hold fifo_full=1 for 7 cycles after the 2nd byte -> no push for 7 cycles; w_data held; 3rd byte pushed on release; no byte lost or duplicated.
- Step: rx 's' -> pipe_en high for exactly 1 cycle, then a full dump starts; debug_mode stays 1.
- Run/halt: rx 'c' -> pipe_en=1, debug_mode=0; raise halted after 50 cycles -> pipe_en=0 next cycle and a dump follows. Repeat with 'p' instead of halted -> same result.
- Unknown and dropped bytes: rx 0x41 in IDLE -> single push of 0x3F. Rx 'd' during an active dump -> ignored; exactly 160 bytes total.
